// File: rtl/sd_drive_arbiter_if.sv
// sd_drive_arbiter_if
//   Bundles the per-client track-loader side and the hps_io SD channel side
//   of the SD drive arbiter.
//   master : arbiter view (drives sd_lba/sd_rd/sd_wr/sd_buff_din and the
//            per-client ack/strobe/broadcast signals).
//   slave  : environment view (track loaders + hps_io SD channel).
//   Client i occupies cl_lba[32i+31:32i] and cl_buff_din[8i+7:8i].
interface sd_drive_arbiter_if #(
    parameter int NUM_CLIENTS = 2
);
    logic [32*NUM_CLIENTS-1:0] cl_lba;
    logic [NUM_CLIENTS-1:0]    cl_rd;
    logic [NUM_CLIENTS-1:0]    cl_wr;
    logic [NUM_CLIENTS-1:0]    cl_ack;
    logic [NUM_CLIENTS-1:0]    cl_buff_wr;
    logic [8*NUM_CLIENTS-1:0]  cl_buff_din;
    logic [8:0]                cl_buff_addr;
    logic [7:0]                cl_buff_dout;

    logic [31:0]               sd_lba;
    logic                      sd_rd;
    logic                      sd_wr;
    logic                      sd_ack;
    logic [8:0]                sd_buff_addr;
    logic                      sd_buff_wr;
    logic [7:0]                sd_buff_dout;
    logic [7:0]                sd_buff_din;

    modport master (
        input  cl_lba, cl_rd, cl_wr, cl_buff_din,
        input  sd_ack, sd_buff_addr, sd_buff_wr, sd_buff_dout,
        output cl_ack, cl_buff_wr, cl_buff_addr, cl_buff_dout,
        output sd_lba, sd_rd, sd_wr, sd_buff_din
    );

    modport slave (
        output cl_lba, cl_rd, cl_wr, cl_buff_din,
        output sd_ack, sd_buff_addr, sd_buff_wr, sd_buff_dout,
        input  cl_ack, cl_buff_wr, cl_buff_addr, cl_buff_dout,
        input  sd_lba, sd_rd, sd_wr, sd_buff_din
    );
endinterface

// File: rtl/sd_drive_arbiter.sv
// sd_drive_arbiter
//   Shares the single MiSTer SD block channel between NUM_CLIENTS Disk II
//   track loaders. Whole multi-sector bursts are granted round-robin; the
//   sector buffer bus is routed to the granted client only.
//
//   Ports:
//     clk, reset   : clock, synchronous active-high reset
//     bus          : sd_drive_arbiter_if.master (client and SD channel signals)
//     grant        : one-hot registered grant, zero when idle
//     busy         : high while a client holds the channel
//     timeout_err  : one-cycle pulse when the first-ack watchdog expires
//
//   Optional: define SD_ARB_TIMEOUT_EN to enable the first-ack watchdog
//   (TIMEOUT_CYCLES). Without it a grant is held until the client releases.
//
//   state  | meaning
//   IDLE   | no grant; waiting for a request with sd_ack low
//   ACTIVE | one client owns the SD channel for a whole burst
module sd_drive_arbiter #(
    parameter int          NUM_CLIENTS    = 2,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd5000000
) (
    input  logic                   clk,
    input  logic                   reset,
    sd_drive_arbiter_if.master     bus,
    output logic [NUM_CLIENTS-1:0] grant,
    output logic                   busy,
    output logic                   timeout_err
);
    localparam int PW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    state_t                 state_q, state_d;
    logic [NUM_CLIENTS-1:0] grant_d;
    logic [PW-1:0]          gidx_q, gidx_d;
    logic [PW-1:0]          last_q, last_d;
    logic                   timeout_d;
    logic [NUM_CLIENTS-1:0] req;
    logic [PW-1:0]          rr_idx;
    logic [PW-1:0]          win_idx;
    logic                   win_found;
    logic                   wd_expire;

    assign req = bus.cl_rd | bus.cl_wr;

    // Scan last+1, last+2, ... so the most recent owner is considered last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        rr_idx    = '0;
        for (int k = 1; k <= NUM_CLIENTS; k++) begin
            rr_idx = PW'((int'(last_q) + k) % NUM_CLIENTS);
            if (!win_found && req[rr_idx]) begin
                win_found = 1'b1;
                win_idx   = rr_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            grant       <= '0;
            gidx_q      <= '0;
            last_q      <= PW'(NUM_CLIENTS - 1);
            timeout_err <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant       <= grant_d;
            gidx_q      <= gidx_d;
            last_q      <= last_d;
            timeout_err <= timeout_d;
        end
    end

    // Grant only changes while sd_ack is low, so a sector is never split
    // between clients and a stale ack after reset cannot leak to a new owner.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant;
        gidx_d    = gidx_q;
        last_d    = last_q;
        timeout_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (win_found && !bus.sd_ack) begin
                    state_d = S_ACTIVE;
                    gidx_d  = win_idx;
                    grant_d = NUM_CLIENTS'(1) << win_idx;
                end
            end
            S_ACTIVE: begin
                if (wd_expire || (!req[gidx_q] && !bus.sd_ack)) begin
                    state_d   = S_IDLE;
                    grant_d   = '0;
                    last_d    = gidx_q;
                    timeout_d = wd_expire;
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    logic [31:0] lba_mux;
    logic        rd_mux;
    logic        wr_mux;
    logic [7:0]  din_mux;

    // Write wins if a client asserts rd and wr together.
    always_comb begin
        lba_mux = '0;
        rd_mux  = 1'b0;
        wr_mux  = 1'b0;
        din_mux = '0;
        if (state_q == S_ACTIVE) begin
            lba_mux = bus.cl_lba[32*gidx_q +: 32];
            wr_mux  = bus.cl_wr[gidx_q];
            rd_mux  = bus.cl_rd[gidx_q] & ~bus.cl_wr[gidx_q];
            din_mux = bus.cl_buff_din[8*gidx_q +: 8];
        end
    end

    assign bus.sd_lba       = lba_mux;
    assign bus.sd_rd        = rd_mux;
    assign bus.sd_wr        = wr_mux;
    assign bus.sd_buff_din  = din_mux;
    assign bus.cl_ack       = {NUM_CLIENTS{bus.sd_ack}} & grant;
    assign bus.cl_buff_wr   = {NUM_CLIENTS{bus.sd_buff_wr & bus.sd_ack}} & grant;
    assign bus.cl_buff_addr = bus.sd_buff_addr;
    assign bus.cl_buff_dout = bus.sd_buff_dout;
    assign busy             = (state_q == S_ACTIVE);

`ifdef SD_ARB_TIMEOUT_EN
    logic [23:0] wd_cnt_q;
    logic        ack_seen_q;
    logic        ack_q;
    logic        grant_start;

    assign grant_start = (state_q == S_IDLE) && (state_d == S_ACTIVE);

    // Only guards the wait for the first ack; once the SD side has answered,
    // slow sectors are left alone for the rest of the grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt_q   <= '0;
            ack_seen_q <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            ack_q <= bus.sd_ack;
            if (grant_start) begin
                wd_cnt_q   <= '0;
                ack_seen_q <= 1'b0;
            end else if (state_q == S_ACTIVE) begin
                if (bus.sd_ack) begin
                    ack_seen_q <= 1'b1;
                    if (!ack_q) wd_cnt_q <= '0;
                end else if (!ack_seen_q) begin
                    wd_cnt_q <= wd_cnt_q + 24'd1;
                end
            end
        end
    end

    assign wd_expire = (state_q == S_ACTIVE) && !bus.sd_ack && !ack_seen_q &&
                       (wd_cnt_q == TIMEOUT_CYCLES - 24'd1);
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign wd_expire          = 1'b0;
`endif
endmodule

// File: tb/tb_sd_drive_arbiter.sv
// tb_sd_drive_arbiter
//   Directed bench for sd_drive_arbiter with two clients: single-client read
//   burst, simultaneous requests, round-robin fairness, write routing, reset
//   during a burst and the first-ack watchdog (SD_ARB_TIMEOUT_EN,
//   TIMEOUT_CYCLES=100). Inputs change and outputs are sampled on the
//   falling clock edge.
module tb_sd_drive_arbiter;
    logic       clk;
    logic       reset;
    logic [1:0] grant;
    logic       busy;
    logic       timeout_err;
    int         n_tests;
    int         n_fail;

    sd_drive_arbiter_if #(.NUM_CLIENTS(2)) bus ();

    sd_drive_arbiter #(
        .NUM_CLIENTS   (2),
        .TIMEOUT_CYCLES(24'd100)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .grant      (grant),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One sector: ack rises (owner drops its request here if last), two
    // buffer strobes, ack falls, one gap cycle; then the grant is checked.
    task automatic sector(input bit last_one, input logic [1:0] g);
        nxt();
        bus.sd_ack = 1'b1;
        if (last_one) begin
            bus.cl_rd = bus.cl_rd & ~g;
            bus.cl_wr = bus.cl_wr & ~g;
        end
        for (int i = 0; i < 2; i++) begin
            nxt();
            bus.sd_buff_wr   = 1'b1;
            bus.sd_buff_addr = 9'(i + 5);
            bus.sd_buff_dout = 8'(8'h40 + i);
            #1;
            chk("sector_grant", grant, g);
            chk("sector_cl_ack", bus.cl_ack, g);
            chk("sector_cl_buff_wr", bus.cl_buff_wr, g);
            chk("sector_buff_addr", bus.cl_buff_addr, 32'(i + 5));
            chk("sector_buff_dout", bus.cl_buff_dout, 32'(8'h40 + i));
            nxt();
            bus.sd_buff_wr = 1'b0;
        end
        nxt();
        bus.sd_ack = 1'b0;
        nxt();
        #1;
        chk("after_sector_grant", grant, last_one ? 2'b00 : g);
    endtask

    initial begin
        int pulses;
        int first_k;
        logic [1:0] grant_at_pulse;
        logic [1:0] grant_after_pulse;

        n_tests = 0;
        n_fail  = 0;
        reset            = 1'b1;
        bus.cl_lba       = {32'd99, 32'd26};
        bus.cl_rd        = 2'b00;
        bus.cl_wr        = 2'b00;
        bus.cl_buff_din  = 16'h0000;
        bus.sd_ack       = 1'b0;
        bus.sd_buff_addr = 9'd0;
        bus.sd_buff_wr   = 1'b0;
        bus.sd_buff_dout = 8'h00;
        nxt(); nxt(); nxt();
        #1;
        chk("rst_grant", grant, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_sd_rd", bus.sd_rd, 1'b0);
        chk("rst_sd_wr", bus.sd_wr, 1'b0);
        chk("rst_sd_lba", bus.sd_lba, 32'd0);
        chk("rst_cl_ack", bus.cl_ack, 2'b00);
        chk("rst_timeout_err", timeout_err, 1'b0);
        nxt();
        reset = 1'b0;

        // Single client read burst of 13 sectors.
        nxt();
        bus.cl_rd = 2'b01;
        #1;
        chk("t1_sd_rd_before_edge", bus.sd_rd, 1'b0);
        nxt();
        #1;
        chk("t1_sd_rd", bus.sd_rd, 1'b1);
        chk("t1_sd_lba", bus.sd_lba, 32'd26);
        chk("t1_grant", grant, 2'b01);
        chk("t1_busy", busy, 1'b1);
        for (int s = 0; s < 12; s++) sector(1'b0, 2'b01);
        sector(1'b1, 2'b01);
        chk("t1_busy_idle", busy, 1'b0);

        // Simultaneous requests after reset: client0 first.
        reset = 1'b1;
        nxt(); nxt();
        reset     = 1'b0;
        bus.cl_rd = 2'b11;
        nxt();
        #1;
        chk("t2_grant_c0", grant, 2'b01);
        sector(1'b1, 2'b01);
        // Fairness: client0 re-requests right away but client1 is due.
        bus.cl_rd[0] = 1'b1;
        nxt();
        #1;
        chk("t2_grant_c1", grant, 2'b10);
        chk("t2_sd_lba_c1", bus.sd_lba, 32'd99);
        sector(1'b1, 2'b10);
        nxt();
        #1;
        chk("t3_grant_c0_again", grant, 2'b01);
        sector(1'b1, 2'b01);

        // Write routing for client1, rd also high: write wins.
        bus.cl_wr       = 2'b10;
        bus.cl_rd       = 2'b10;
        bus.cl_buff_din = 16'hA55A;
        #1;
        chk("t4_din_idle", bus.sd_buff_din, 8'h00);
        nxt();
        #1;
        chk("t4_grant", grant, 2'b10);
        chk("t4_sd_wr", bus.sd_wr, 1'b1);
        chk("t4_sd_rd", bus.sd_rd, 1'b0);
        chk("t4_sd_buff_din", bus.sd_buff_din, 8'hA5);
        chk("t4_sd_lba", bus.sd_lba, 32'd99);
        sector(1'b1, 2'b10);

        // Reset during sector 5 with sd_ack held high.
        bus.cl_rd = 2'b01;
        nxt();
        #1;
        chk("t5_grant", grant, 2'b01);
        for (int s = 0; s < 4; s++) sector(1'b0, 2'b01);
        nxt();
        bus.sd_ack = 1'b1;
        nxt();
        reset = 1'b1;
        nxt();
        #1;
        chk("t5_sd_rd_after_reset", bus.sd_rd, 1'b0);
        chk("t5_grant_after_reset", grant, 2'b00);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            nxt();
            #1;
            chk("t5_no_grant_ack_high", grant, 2'b00);
        end
        nxt();
        bus.sd_ack = 1'b0;
        #1;
        chk("t5_grant_ack_fall", grant, 2'b00);
        nxt();
        #1;
        chk("t5_regrant", grant, 2'b01);
        chk("t5_regrant_sd_rd", bus.sd_rd, 1'b1);
        bus.cl_rd = 2'b00;
        nxt();
        #1;
        chk("t5_release", grant, 2'b00);

        // No ack ever: client1 is due (last=0).
        bus.cl_rd = 2'b11;
        nxt();
        #1;
        chk("t6_grant", grant, 2'b10);
        pulses            = 0;
        first_k           = 0;
        grant_at_pulse    = 2'b11;
        grant_after_pulse = 2'b11;
        for (int k = 1; k <= 150; k++) begin
            nxt();
            #1;
            if (timeout_err) begin
                pulses++;
                if (first_k == 0) begin
                    first_k        = k;
                    grant_at_pulse = grant;
                end
            end
            if (first_k != 0 && k == first_k + 1) grant_after_pulse = grant;
        end
`ifdef SD_ARB_TIMEOUT_EN
        chk("t6_pulse_count", pulses, 1);
        chk("t6_pulse_cycle", first_k, 100);
        chk("t6_grant_at_pulse", grant_at_pulse, 2'b00);
        chk("t6_next_grant", grant_after_pulse, 2'b01);
        chk("t6_grant_end", grant, 2'b01);
`else
        chk("t6_no_pulse", pulses, 0);
        chk("t6_grant_held", grant, 2'b10);
        chk("t6_busy_held", busy, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
